// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    CHECK,
    DATA,
    RUN,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words. The finished word is held
// in 'word' until the next word completes, so it doubles as the Imem data bus.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  input  logic        clear,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] partial;

  // Collect bytes 0..2 in the partial buffer; byte 3 completes the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial   <= '0;
      byte_idx  <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (clear) begin
        partial  <= '0;
        byte_idx <= '0;
      end else if (accept) begin
        if (byte_idx == LAST_IDX) begin
          word      <= {byte_in, partial};
          word_done <= 1'b1;
          byte_idx  <= '0;
        end else begin
          case (byte_idx)
            2'd0:    partial[7:0]   <= byte_in;
            2'd1:    partial[15:8]  <= byte_in;
            default: partial[23:16] <= byte_in;
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream:
// 2-byte little-endian word count, then 4 bytes per instruction.
//
// state  | meaning
// IDLE   | waiting for load_req after reset
// HDR_LO | taking word-count low byte
// HDR_HI | taking word-count high byte
// CHECK  | validating the word count (no bytes taken)
// DATA   | taking instruction bytes, one Imem write per word
// RUN    | program loaded, start held high
// ERR    | word count rejected, error held high
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      Imem_write_instr,
  output logic             Imem_write_en,
  output logic             start,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  localparam int               HDR_W = 8 * HDR_BYTES;
  localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  loader_state_t    state;
  logic [HDR_W-1:0] hdr;
  logic [CNT_W-1:0] words_left;
  logic             byte_take;
  logic             data_accept;
  logic             hdr_bad;
  logic [1:0]       pk_idx;
  logic [31:0]      pk_word;
  logic             pk_done;

  assign byte_take   = byte_valid && byte_ready;
  assign data_accept = byte_take && (state == DATA);
  assign hdr_bad     = (hdr == '0) || (hdr > MAX_N);

  // Write strobe and data come straight from the packer's registers.
  assign Imem_write_instr = pk_word;
  assign Imem_write_en    = pk_done;

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .accept    (data_accept),
    .clear     (state == CHECK),
    .byte_idx  (pk_idx),
    .word      (pk_word),
    .word_done (pk_done)
  );

  // Load sequencer; words_left counts down to the last write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      hdr           <= '0;
      words_left    <= '0;
      words_written <= '0;
      byte_ready    <= 1'b0;
      start         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            state      <= HDR_LO;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        HDR_LO: begin
          if (byte_take) begin
            hdr[7:0] <= byte_in;
            state    <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (byte_take) begin
            hdr[15:8]  <= byte_in;
            state      <= CHECK;
            byte_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (hdr_bad) begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state         <= DATA;
            words_written <= '0;
            words_left    <= CNT_W'(hdr);
            byte_ready    <= 1'b1;
          end
        end
        DATA: begin
          if (data_accept && (pk_idx == 2'd3)) begin
            words_written <= words_written + ONE;
            words_left    <= words_left - ONE;
            // Stop taking bytes once the final byte is in, so extras stay put.
            if (words_left == ONE) byte_ready <= 1'b0;
          end
          if (pk_done && (words_left == '0)) begin
            state <= RUN;
            start <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (load_req) begin
            state      <= HDR_LO;
            start      <= 1'b0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
        end
        ERR: begin
          if (load_req) begin
            state      <= HDR_LO;
            error      <= 1'b0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          start      <= 1'b0;
          busy       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every Imem write strobe.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] Imem_write_instr;
  logic        Imem_write_en;
  logic        start;
  logic        busy;
  logic        error;
  logic [6:0]  words_written;

  typedef struct {
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  imem_loader #(.MAX_WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_req         (load_req),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .Imem_write_instr (Imem_write_instr),
    .Imem_write_en    (Imem_write_en),
    .start            (start),
    .busy             (busy),
    .error            (error),
    .words_written    (words_written)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input int c);
    exp_t e;
    e.word = w;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Every strobe cycle must match the next expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && Imem_write_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got %h expected no write", Imem_write_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_word", Imem_write_instr, e.word);
        chk("write_count", 32'(words_written), e.cnt);
      end
    end
  end

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout: got 0 expected 1 for byte %h", b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_prog(input logic [7:0] b[$], input int gap);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      if (i != b.size() - 1) repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Called right after the last byte is taken: strobe now, start next cycle.
  task automatic finish_check(input int n);
    chk("last_strobe", 32'(Imem_write_en), 32'd1);
    chk("start_during_strobe", 32'(start), 32'd0);
    @(posedge clk); #1;
    chk("start_after_last", 32'(start), 32'd1);
    chk("busy_in_run", 32'(busy), 32'd0);
    chk("ready_in_run", 32'(byte_ready), 32'd0);
    chk("words_written_final", 32'(words_written), 32'(n));
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {27'd0, byte_ready, Imem_write_en, start, busy, error}, 32'd0);
    chk({tag, "_instr"}, Imem_write_instr, 32'd0);
    chk({tag, "_count"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    logic [7:0] prog[$];
    reset      = 1'b0;
    load_req   = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(byte_ready), 32'd0);

    // Nominal 2-word load, continuous stream.
    pulse_load();
    chk("busy_hdr", 32'(busy), 32'd1);
    push_exp(32'h00500113, 1);
    push_exp(32'h01910113, 2);
    prog = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h13, 8'h01, 8'h91, 8'h01};
    send_prog(prog, 0);
    finish_check(2);

    // Same program, stalled stream; reload from RUN.
    pulse_load();
    chk("reload_start_low", 32'(start), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    push_exp(32'h00500113, 1);
    push_exp(32'h01910113, 2);
    send_prog(prog, 2);
    finish_check(2);

    // Zero header.
    pulse_load();
    prog = {8'h00, 8'h00};
    send_prog(prog, 0);
    @(posedge clk); #1;
    chk("zero_error", 32'(error), 32'd1);
    chk("zero_ready", 32'(byte_ready), 32'd0);
    chk("zero_start", 32'(start), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    pulse_load();
    chk("zero_clear_error", 32'(error), 32'd0);
    chk("zero_clear_ready", 32'(byte_ready), 32'd1);

    // Oversize header (65 words).
    prog = {8'h41, 8'h00};
    send_prog(prog, 1);
    @(posedge clk); #1;
    chk("over_error", 32'(error), 32'd1);
    chk("over_ready", 32'(byte_ready), 32'd0);
    pulse_load();
    chk("over_clear_error", 32'(error), 32'd0);

    // Reset after 6 data bytes of a 2-word load.
    push_exp(32'h00500113, 1);
    prog = {8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h13, 8'h01};
    send_prog(prog, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_sb", sb.size(), 32'd0);
    pulse_load();
    push_exp(32'hDEADBEEF, 1);
    prog = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_prog(prog, 0);
    finish_check(1);

    // Extra bytes in RUN are not consumed.
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("run_no_ready", 32'(byte_ready), 32'd0);
    chk("run_start_held", 32'(start), 32'd1);
    byte_valid = 1'b0;

    // Reload from RUN with a 1-word program.
    pulse_load();
    chk("reload2_start_low", 32'(start), 32'd0);
    chk("reload2_busy", 32'(busy), 32'd1);
    push_exp(32'h00000013, 1);
    prog = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_prog(prog, 1);
    finish_check(1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("instr_hold", Imem_write_instr, 32'h00000013);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
